// File: rtl/sched_issue_ctrl.sv
// Drain stage between the scheduler shift queue head and the DRAM command bus.
// Applies same-direction (T_CCD) and turnaround (T_WTR/T_RTW) spacing and pops the queue on accept.
module sched_issue_ctrl #(
  parameter int T_CCD = 4,
  parameter int T_WTR = 6,
  parameter int T_RTW = 3,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in_q,
  input  logic        rw_in_q,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic        cmd_rw,
  output logic        sh_en,
  output logic [1:0]  state,
  output logic        turnaround_stall,
  output logic [15:0] rd_issued,
  output logic [15:0] wr_issued
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ISSUE  = 2'd2,
    UNUSED = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CCD_C = CNT_W'(T_CCD);
  localparam logic [CNT_W-1:0] WTR_C = CNT_W'(T_WTR);
  localparam logic [CNT_W-1:0] RTW_C = CNT_W'(T_RTW);
  localparam logic [CNT_W-1:0] SAT_C = '1;

  state_e           state_q, state_d;
  logic             last_valid_q;
  logic             last_rw_q;
  logic [CNT_W-1:0] since_q, since_d;
  logic [15:0]      rd_q, wr_q;
  logic             ok;
  logic             accept;

  always_comb begin
    ok = 1'b1;
    if (last_valid_q) begin
      if (rw_in_q == last_rw_q)
        ok = (since_q >= CCD_C);
      else if (last_rw_q)
        ok = (since_q >= WTR_C);
      else
        ok = (since_q >= RTW_C);
    end
  end

  // Handshake outputs are gated by reset so they drop without waiting for an edge.
  assign cmd_valid        = rst & valid_in_q & ok;
  assign cmd_rw           = rw_in_q;
  assign accept           = cmd_valid & cmd_ready;
  assign sh_en            = accept;
  assign turnaround_stall = rst & valid_in_q & last_valid_q & (rw_in_q != last_rw_q) & ~ok;

  always_comb begin
    state_d = IDLE;
    if (valid_in_q)
      state_d = ok ? ISSUE : WAIT;
  end

  always_comb begin
    since_d = since_q;
    if (accept)
      since_d = {{(CNT_W-1){1'b0}}, 1'b1};
    else if (since_q != SAT_C)
      since_d = since_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_valid_q <= 1'b0;
      last_rw_q    <= 1'b0;
      since_q      <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
    end else begin
      state_q <= state_d;
      since_q <= since_d;
      if (accept) begin
        last_valid_q <= 1'b1;
        last_rw_q    <= rw_in_q;
        if (rw_in_q)
          wr_q <= wr_q + 16'd1;
        else
          rd_q <= rd_q + 16'd1;
      end
    end
  end

  assign state     = state_q;
  assign rd_issued = rd_q;
  assign wr_issued = wr_q;

endmodule
